// File: rtl/clock_display_pkg.sv
// rtl/clock_display_pkg.sv - segment codes and converter state type for the clock display
package clock_display_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Any digit register value above 9 is rendered as a dash
  localparam logic [3:0] DIGIT_DASH = 4'hA;

  typedef enum logic [1:0] {IDLE, CONV_HI, CONV_LO, COMMIT} conv_state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - repeated-subtraction binary to two-digit decimal converter
module bin2bcd_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] value,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf
);

  logic       busy;
  logic [6:0] rem;

  // One subtraction of 10 per cycle; values above 99 finish at once flagged as overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      rem  <= '0;
      tens <= '0;
      ones <= '0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        tens <= '0;
        ones <= '0;
        ovf  <= (value > 8'd99);
        rem  <= value[6:0];
      end else if (busy) begin
        if (ovf) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else if (rem >= 7'd10) begin
          rem  <= rem - 7'd10;
          tens <= tens + 4'd1;
        end else begin
          ones <= rem[3:0];
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_display_scanner.sv
// rtl/clock_display_scanner.sv - multiplexed 4-digit 7-segment driver with blinking colon
module clock_display_scanner
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] display_num,
  input  logic        colon_en,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

  if (SCAN_DIV < 8) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 8");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be at least 1");
  end

  logic [CW-1:0]   cnt;
  logic [1:0]      d;
  logic [FW-1:0]   fcnt;
  logic            phase;
  logic [15:0]     shadow;
  conv_state_t     state;
  logic            start_r;
  logic [3:0]      hi_tens;
  logic [3:0]      hi_ones;
  logic            hi_ovf;
  logic [3:0][3:0] digits;
  logic            frame_end;
  logic [7:0]      conv_value;
  logic            conv_done;
  logic [3:0]      conv_tens;
  logic [3:0]      conv_ones;
  logic            conv_ovf;

  assign frame_end  = (cnt == CNT_LAST) && (d == 2'd3);
  assign conv_value = (state == CONV_LO) ? shadow[7:0] : shadow[15:8];

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start_r),
    .value (conv_value),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones),
    .ovf   (conv_ovf)
  );

  // Slot counter and digit index; a frame is four slots
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      d   <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      d   <= d + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Colon phase flips every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (frame_end) begin
      if (fcnt == BLINK_LAST) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // Latch at frame end, convert upper then lower byte, publish all four digits together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_r <= 1'b0;
      shadow  <= '0;
      hi_tens <= '0;
      hi_ones <= '0;
      hi_ovf  <= 1'b0;
      digits  <= '0;
    end else begin
      start_r <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_end) begin
            shadow  <= display_num;
            start_r <= 1'b1;
            state   <= CONV_HI;
          end
        end
        CONV_HI: begin
          if (conv_done) begin
            hi_tens <= conv_tens;
            hi_ones <= conv_ones;
            hi_ovf  <= conv_ovf;
            start_r <= 1'b1;
            state   <= CONV_LO;
          end
        end
        CONV_LO: begin
          if (conv_done) state <= COMMIT;
        end
        COMMIT: begin
          digits[3] <= hi_ovf   ? DIGIT_DASH : hi_tens;
          digits[2] <= hi_ovf   ? DIGIT_DASH : hi_ones;
          digits[1] <= conv_ovf ? DIGIT_DASH : conv_tens;
          digits[0] <= conv_ovf ? DIGIT_DASH : conv_ones;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered display drive; slot cycle 0 is blanked to hide ghosting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      dp_n       <= ~(colon_en && phase && (d == 2'd2) && (cnt != '0));
      if (cnt == '0) begin
        an_n  <= 4'hF;
        seg_n <= SEG_OFF;
      end else begin
        an_n  <= ~(4'b0001 << d);
        seg_n <= seg_code(digits[d]);
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scanner.sv
// tb/tb_clock_display_scanner.sv - scoreboard bench for clock_display_scanner
module tb_clock_display_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] display_num;
  logic        colon_en;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  localparam logic [6:0] C0 = 7'b1000000, C1 = 7'b1111001, C2 = 7'b0100100;
  localparam logic [6:0] C3 = 7'b0110000, C4 = 7'b0011001, C5 = 7'b0010010;
  localparam logic [6:0] C9 = 7'b0010000, CD = 7'b0111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic cur_valid;
  logic [3:0] prev_an;
  int total = 0;
  int bad = 0;
  int nfd = 0;

  clock_display_scanner #(.SCAN_DIV(8), .BLINK_FRAMES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .display_num (display_num),
    .colon_en    (colon_en),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Colon phase for frame k (1-based since reset release) with BLINK_FRAMES=2
  function automatic logic slot2_dp(input int k);
    return !(colon_en && ((((k - 1) / 2) % 2) == 1));
  endfunction

  // Expected slots of the next frame, in display order d0..d3
  task automatic expect_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    q.push_back('{an: 4'b1110, seg: s0, dp: 1'b1});
    q.push_back('{an: 4'b1101, seg: s1, dp: 1'b1});
    q.push_back('{an: 4'b1011, seg: s2, dp: slot2_dp(nfd + 1)});
    q.push_back('{an: 4'b0111, seg: s3, dp: 1'b1});
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (frame_done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL frame_timeout actual=no_frame_done required=frame_done t=%0t", $time);
    end
    nfd++;
  endtask

  task automatic show(input logic [15:0] num, input logic [6:0] s3, input logic [6:0] s2,
                      input logic [6:0] s1, input logic [6:0] s0);
    display_num = num;
    wait_frame();
    wait_frame();
    expect_frame(s3, s2, s1, s0);
    wait_frame();
  endtask

  // Monitor: each lit slot pops one expectation and is checked on every cycle it is shown
  always @(negedge clk) begin
    if (!reset) begin
      cur_valid = 1'b0;
      prev_an   = 4'hF;
    end else begin
      if (an_n == 4'hF) begin
        cur_valid = 1'b0;
      end else if (prev_an == 4'hF && q.size() > 0) begin
        cur       = q.pop_front();
        cur_valid = 1'b1;
      end
      if (cur_valid) begin
        total++;
        if (an_n !== cur.an || seg_n !== cur.seg || dp_n !== cur.dp) begin
          bad++;
          $display("FAIL slot actual an=%b seg=%b dp=%b required an=%b seg=%b dp=%b t=%0t",
                   an_n, seg_n, dp_n, cur.an, cur.seg, cur.dp, $time);
        end
      end
      prev_an = an_n;
    end
  end

  initial begin
    reset       = 1'b0;
    display_num = 16'h0000;
    colon_en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", {9'd0, seg_n}, 16'h007F);
    check("rst_dp", {15'd0, dp_n}, 16'h0001);
    check("rst_an", {12'd0, an_n}, 16'h000F);
    check("rst_fd", {15'd0, frame_done}, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    check("cycle0_blank", {12'd0, an_n}, 16'h000F);
    expect_frame(C0, C0, C0, C0);
    wait_frame();

    show(16'h3B0C, C5, C9, C1, C2);
    show(16'h6463, CD, CD, C9, C9);
    show(16'h0102, C0, C1, C0, C2);

    // Mid-frame change: this frame keeps the old value
    expect_frame(C0, C1, C0, C2);
    repeat (10) @(negedge clk);
    display_num = 16'h0304;
    wait_frame();
    wait_frame();
    expect_frame(C0, C3, C0, C4);
    wait_frame();

    // Colon blinking over consecutive frames, then disabled
    colon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_frame(C0, C3, C0, C4);
      wait_frame();
    end
    colon_en = 1'b0;
    expect_frame(C0, C3, C0, C4);
    wait_frame();

    // Reset in the middle of a conversion
    display_num = 16'h3B3B;
    wait_frame();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_seg", {9'd0, seg_n}, 16'h007F);
    check("midrst_dp", {15'd0, dp_n}, 16'h0001);
    check("midrst_an", {12'd0, an_n}, 16'h000F);
    check("midrst_fd", {15'd0, frame_done}, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    nfd = 0;
    expect_frame(C0, C0, C0, C0);
    wait_frame();

    check("queue_drained", 16'(q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
